// File: rtl/iter_shift_unit_pkg.sv
// ---------------------------------------------------------------------------
// iter_shift_defs
//   Shared definitions for the iterative shift/rotate unit.
//   - op_t    : operation encodings, identical to the ALU_Control shift
//               sub-field of the Mini-SRC datapath (101..111 are reserved).
//   - state_t : control FSM states of iter_shift_unit.
//   - op_is_legal() : true for the five implemented operations.
// ---------------------------------------------------------------------------
package iter_shift_defs;

    typedef enum logic [2:0] {
        OP_SHR  = 3'b000,
        OP_SHRA = 3'b001,
        OP_SHL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Codes above OP_ROL are reserved and must be flagged, not executed.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'b100);
    endfunction

endpackage

// File: rtl/iter_shift_unit_shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
//   Purely combinational single-step shifter used by iter_shift_unit.
//   Applies k (0..STEP) positions of the selected operation to data.
//
//   Ports:
//     data     in  WIDTH  working value before this step
//     op       in  3      operation (see iter_shift_defs::op_t)
//     k        in  KW     positions to apply this step, 0..STEP
//     shifted  out WIDTH  value after this step
//     bit_out  out 1      last bit shifted out (shifts) or wrapped (rotates);
//                         0 when k=0 or op is reserved
// ---------------------------------------------------------------------------
module shift_step
    import iter_shift_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] shifted,
    output logic             bit_out
);

    logic signed [WIDTH-1:0] data_s;
    logic                    right_bit;
    logic                    left_bit;

    assign data_s = $signed(data);

    always_comb begin
        shifted = data;
        case (op)
            OP_SHR:  shifted = data >> k;
            OP_SHRA: shifted = data_s >>> k;
            OP_SHL:  shifted = data << k;
            // A shift by WIDTH yields zero, so k=0 leaves data unchanged.
            OP_ROR:  shifted = (data >> k) | (data << (WIDTH - int'(k)));
            OP_ROL:  shifted = (data << k) | (data >> (WIDTH - int'(k)));
            default: shifted = data;
        endcase
    end

    // The last bit leaving the register is data[k-1] for right moves and
    // data[WIDTH-k] for left moves; for rotates that same bit is the one
    // that wraps to the MSB (ROR) or LSB (ROL) of the result.
    always_comb begin
        right_bit = 1'b0;
        left_bit  = 1'b0;
        for (int i = 1; i <= STEP; i++) begin
            if (k == KW'(i)) begin
                right_bit = data[i-1];
                left_bit  = data[WIDTH-i];
            end
        end
    end

    always_comb begin
        bit_out = 1'b0;
        case (op)
            OP_SHR, OP_SHRA, OP_ROR: bit_out = right_bit;
            OP_SHL, OP_ROL:          bit_out = left_bit;
            default:                 bit_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// ---------------------------------------------------------------------------
// iter_shift_unit
//   Multi-cycle shift/rotate unit for the Mini-SRC ALU path. A request is
//   accepted with start in IDLE or DONE; the operand is then shifted by up to
//   STEP positions per cycle in SHIFT, and the result is presented with a
//   one-cycle done pulse. The control unit holds T4 until done.
//
//   Ports:
//     clock      in   1      system clock, rising edge
//     clear      in   1      synchronous active-low reset
//     start      in   1      request, sampled when in IDLE or DONE
//     op         in   3      SHR/SHRA/SHL/ROR/ROL, 101..111 reserved
//     operand    in   WIDTH  value to shift
//     amount     in   CNT_W  unsigned shift count
//     busy       out  1      high while shifting
//     done       out  1      one-cycle completion pulse
//     result     out  WIDTH  shifted value, held until next accepted start
//     carry_out  out  1      last bit shifted out / wrapped
//     op_err     out  1      high with done for a reserved op
// ---------------------------------------------------------------------------
module iter_shift_unit
    import iter_shift_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             op_err
);

    localparam int KW = $clog2(STEP + 1);

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] work;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] remaining;
    logic             op_err_q;

    logic             accept;
    logic             go_shift;
    logic             last_step;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    // Requests are only taken when no shift is in flight; starts during
    // SHIFT are dropped, not queued.
    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
    assign go_shift = op_is_legal(op) && (amount != '0);

    // Positions applied this cycle: min(remaining, STEP).
    always_comb begin
        k = KW'(remaining);
        if (int'(remaining) >= STEP) begin
            k = KW'(STEP);
        end
    end

    // k never exceeds remaining, so equality marks the final step.
    assign last_step = (state == S_SHIFT) && (CNT_W'(k) == remaining);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data    (work),
        .op      (op_q),
        .k       (k),
        .shifted (step_data),
        .bit_out (step_bit)
    );

    // ---- control FSM: state register ----
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---- control FSM: next state ----
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nx = go_shift ? S_SHIFT : S_DONE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---- working registers and output registers ----
    always_ff @(posedge clock) begin
        if (!clear) begin
            work      <= '0;
            op_q      <= '0;
            remaining <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            op_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                work      <= operand;
                op_q      <= op;
                remaining <= amount;
            end else if (state == S_SHIFT) begin
                work      <= step_data;
                remaining <= remaining - CNT_W'(k);
            end

            // Result/carry change only when entering DONE, so they stay
            // stable through SHIFT of a following request.
            if (accept && !go_shift) begin
                result    <= operand;
                carry_out <= 1'b0;
            end else if (last_step) begin
                result    <= step_data;
                carry_out <= step_bit;
            end

            // Only an accept that goes straight to DONE can flag an error,
            // and the flag drops on the next edge together with done.
            op_err_q <= accept && !op_is_legal(op);
        end
    end

    assign busy   = (state == S_SHIFT);
    assign done   = (state == S_DONE);
    assign op_err = op_err_q;

endmodule
